// File: rtl/simd_issue_queue.sv
// simd_issue_queue: circular-buffer issue queue feeding a 4x8-bit SIMD ALU, dropping illegal opcode mixes.
// Optional SIMD_ISSUE_BYPASS_EN: entries arriving at an empty, unstalled queue issue on the accept edge.
module simd_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [15:0]              in_opcode,
    input  logic [3:0]               in_cin,
    input  logic                     alu_stall,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [15:0]              alu_opcode,
    output logic [3:0]               alu_cin,
    output logic                     alu_valid,
    output logic                     res_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);

    // 1110/1111 are reserved; 1100 (matrix) owns the full width and may only share with 0000 lanes
    function automatic logic illegal(input logic [15:0] op);
        logic bad, mat, oth;
        bad = 1'b0;
        mat = 1'b0;
        oth = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bad |= op[4*k +: 4] >= 4'he;
            mat |= op[4*k +: 4] == 4'hc;
            oth |= op[4*k +: 4] != 4'hc && op[4*k +: 4] != 4'h0;
        end
        return bad | (mat & oth);
    endfunction

    logic [83:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [83:0]   in_entry, sel;
    logic          accept, bypass, push, pop, take, bad;

    assign in_entry = {in_a, in_b, in_opcode, in_cin};
    assign in_ready = count < (AW+1)'(DEPTH);
    assign accept   = in_valid && in_ready;
`ifdef SIMD_ISSUE_BYPASS_EN
    assign bypass   = accept && count == '0 && !alu_stall;
`else
    assign bypass   = 1'b0;
`endif
    assign push     = accept && !bypass;
    assign pop      = count != '0 && !alu_stall;
    assign sel      = bypass ? in_entry : mem[rd_ptr];
    assign take     = bypass || pop;
    assign bad      = illegal(sel[19:4]);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_cin    <= '0;
            alu_valid  <= 1'b0;
            res_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            alu_valid <= take && !bad;
            res_valid <= alu_valid;
            if (take && !bad) {alu_a, alu_b, alu_opcode, alu_cin} <= sel;
            if (take && bad) err <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: doc/simd_issue_queue.md
SIMD_ISSUE_QUEUE -- requirements
Module: simd_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream entry valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept entry.
REQ-006 SHALL have ports in_a, in_b  input  32 each  packed 4x8-bit lane operands.
REQ-007 SHALL have port in_opcode  input  16  four 4-bit lane opcodes, lane k = [4k+3:4k].
REQ-008 SHALL have port in_cin  input  4  per-lane carry/borrow-in.
REQ-009 SHALL have port alu_stall  input  1  downstream hold; no issue while high.
REQ-010 SHALL have ports alu_a, alu_b  output  32 each  registered operands to SIMD ALU.
REQ-011 SHALL have port alu_opcode  output  16  registered opcode to ALU.
REQ-012 SHALL have port alu_cin  output  4  registered carry-in to ALU.
REQ-013 SHALL have port alu_valid  output  1  one-cycle pulse per issued entry.
REQ-014 SHALL have port res_valid  output  1  ALU output register holds the result of the entry issued one cycle earlier.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port err  output  1  sticky illegal-opcode flag.

Function
REQ-017 SHALL accept an entry on a cycle with in_valid && in_ready; in_ready = (count < DEPTH).
REQ-018 SHALL store {a, b, opcode, cin} in a circular buffer with wrapping read/write pointers.
REQ-019 SHALL issue the head entry when count > 0 && !alu_stall: load alu_* from the head, pulse alu_valid, and advance the read pointer.
REQ-020 SHALL hold alu_a/alu_b/alu_opcode/alu_cin unchanged on cycles without an issue; alu_valid SHALL be 0 on those cycles.
REQ-021 SHALL set res_valid = alu_valid delayed by one cycle, matching the ALU's single register stage.
REQ-022 SHALL treat an entry as illegal if any lane opcode is 4'b1110 or 4'b1111, or if lane opcode 4'b1100 (full-width matrix) coexists with any non-1100, non-0000 lane opcode.
REQ-023 SHALL drop an illegal entry at issue (consume the head, no alu_valid pulse) and set err; err clears only on reset.
REQ-024 SHALL, on simultaneous accept and issue, keep count unchanged; at count==DEPTH this case SHALL NOT occur because in_ready=0.
REQ-025 SHALL have latency in->alu_valid of 2 cycles minimum (accept edge T, issue edge T+1), without bypass.
REQ-026 SHALL ignore in_* when in_valid=0 or in_ready=0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear pointers, count, alu_a, alu_b, alu_opcode, alu_cin, alu_valid, res_valid, and err to 0; in_ready SHALL be 1 after reset.
REQ-028 SHALL discard all queued entries on a reset asserted mid-operation; no alu_valid SHALL follow reset release until a new entry is accepted.

Configuration
REQ-029 SHALL support macro SIMD_ISSUE_BYPASS_EN: when defined, an entry accepted while count==0 and alu_stall==0 is legal-checked and loaded directly into alu_* on the accept edge (alu_valid the same edge, count unchanged); when undefined, every entry passes through the FIFO (REQ-025).

Verification
REQ-030 Reset then accept a=0x04030201, b=0x01010101, opcode=0x1111, cin=0 -> alu_valid 2 cycles after accept (1 with SIMD_ISSUE_BYPASS_EN), alu_a=0x04030201, res_valid one cycle later.
REQ-031 alu_stall=1, push 5 entries with DEPTH=4 -> count=4, in_ready=0, 5th not accepted; release stall -> four alu_valid pulses in push order on consecutive cycles.
REQ-032 Push opcode=0x00F1 -> no alu_valid for that entry, err=1 and stays 1; following legal entry issues normally.
REQ-033 Push opcode=0x1C00 (matrix mixed with ADD) -> dropped, err=1; push opcode=0xCCCC -> issued.
REQ-034 Queue 3 entries, drop reset_n for one cycle mid-drain -> count=0, alu_valid=0, res_valid=0, err=0 immediately; no stale issue afterward.
REQ-035 Continuous in_valid with alu_stall=0 for 20 cycles -> one issue per cycle, count steady, pointers wrap without loss or reorder.
